// File: rtl/ysyx_25010008_axil_sram.sv
// AXI4-Lite responder over a word-addressed SRAM model.
// One transaction at a time, programmable response latency.
module ysyx_25010008_axil_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 1,
  parameter int          WR_LAT      = 1,
  parameter int          RAND_LAT    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_DATA,
    WR_WAIT,
    WR_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        rvalid_q, rvalid_d;
  logic        bvalid_q, bvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic          in_rng;
  logic [AW-1:0] idx;
  logic [7:0]    rnd;
  logic          mem_we;
  logic          unused_ok;

  assign unused_ok = ^{arsize, awsize};

  // Wrapping subtract turns addresses below the base into huge offsets.
  assign off    = addr_q - BASE_ADDR;
  assign in_rng = {1'b0, off} < SPAN;
  assign idx    = off[AW+1:2];
  assign rnd    = (RAND_LAT != 0) ? {6'd0, lfsr_q[1:0]} : 8'd0;
  assign lfsr_d = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign arready = (state_q == IDLE);
  assign awready = (state_q == IDLE) & ~arvalid;
  assign wready  = (state_q == WR_DATA);
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    bvalid_d = bvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    bresp_d  = bresp_q;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arvalid) begin
          addr_d  = araddr;
          cnt_d   = 8'(RD_LAT - 1) + rnd;
          state_d = RD_WAIT;
        end else if (awvalid) begin
          addr_d  = awaddr;
          state_d = WR_DATA;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 8'd0) begin
          rdata_d  = in_rng ? mem[idx] : 32'd0;
          rresp_d  = in_rng ? OKAY : SLVERR;
          rvalid_d = 1'b1;
          state_d  = RD_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      WR_DATA: begin
        if (wvalid) begin
          mem_we  = in_rng;
          cnt_d   = 8'(WR_LAT - 1) + rnd;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 8'd0) begin
          bresp_d  = in_rng ? OKAY : SLVERR;
          bvalid_d = 1'b1;
          state_d  = WR_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      cnt_q    <= 8'd0;
      lfsr_q   <= SEED;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= 2'b00;
      bresp_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bresp_q  <= bresp_d;
    end
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_axil_sram.sv
// Directed self-checking bench for ysyx_25010008_axil_sram.
// Non-default latencies make the timing checks meaningful.
module tb_ysyx_25010008_axil_sram;

  localparam int RDL = 2;
  localparam int WRL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arsize = 3'd2;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic [2:0]  awsize = 3'd2;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_25010008_axil_sram #(
    .BASE_ADDR(32'h8000_0000),
    .DEPTH_WORDS(4096),
    .RD_LAT(RDL),
    .WR_LAT(WRL),
    .RAND_LAT(0)
  ) dut (
    .clock(clk), .reset(rst_n),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic ar_req(input logic [31:0] a);
    int n = 0;
    while (!arready && n < 50) begin step(); n++; end
    araddr = a;
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
  endtask

  task automatic r_wait(input string tag, output int lat);
    lat = 0;
    do begin step(); lat++; end while (!rvalid && lat < 50);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
  endtask

  task automatic r_take;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] ed, input logic [1:0] er);
    int lat;
    ar_req(a);
    r_wait(tag, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(RDL));
    chk({tag, "_data"}, rdata, ed);
    chk({tag, "_resp"}, 32'(rresp), 32'(er));
    r_take();
  endtask

  task automatic aw_req(input logic [31:0] a);
    int n = 0;
    while (!awready && n < 50) begin step(); n++; end
    awaddr = a;
    awvalid = 1'b1;
    step();
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    step();
    wvalid = 1'b0;
  endtask

  task automatic b_wait(input string tag, output int lat);
    lat = 0;
    do begin step(); lat++; end while (!bvalid && lat < 50);
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
  endtask

  task automatic b_take;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er);
    int lat;
    aw_req(a);
    w_send(d, s);
    b_wait(tag, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(WRL));
    chk({tag, "_bresp"}, 32'(bresp), 32'(er));
    b_take();
  endtask

  initial begin
    int lat;
    logic [31:0] d0;
    logic [1:0]  r0;
    logic        stable;

    repeat (2) step();
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", {28'd0, rresp, bresp}, 32'd0);
    rst_n = 1'b1;
    step();

    wr("w_full", 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 2'b00);
    rd("r_full", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

    wr("w_base", 32'h8000_0010, 32'h1122_3344, 4'b1111, 2'b00);
    wr("w_byte", 32'h8000_0011, 32'h0000_AB00, 4'b0010, 2'b00);
    rd("r_byte", 32'h8000_0010, 32'h1122_AB44, 2'b00);

    wr("w_w0", 32'h8000_0000, 32'hCAFE_F00D, 4'b1111, 2'b00);
    wr("w_last", 32'h8000_3FFC, 32'h7777_8888, 4'b1111, 2'b00);
    rd("r_low_oor", 32'h7FFF_FFFC, 32'h0000_0000, 2'b10);
    wr("w_high_oor", 32'h8000_4000, 32'h5555_5555, 4'b1111, 2'b10);
    rd("r_w0_kept", 32'h8000_0000, 32'hCAFE_F00D, 2'b00);
    rd("r_last", 32'h8000_3FFC, 32'h7777_8888, 2'b00);
    rd("r_high_oor", 32'h8000_4000, 32'h0000_0000, 2'b10);

    araddr = 32'h8000_0010;
    awaddr = 32'h8000_0020;
    arvalid = 1'b1;
    awvalid = 1'b1;
    #1;
    chk("both_arready", 32'(arready), 32'd1);
    chk("both_awready", 32'(awready), 32'd0);
    step();
    arvalid = 1'b0;
    stable = 1'b1;
    lat = 0;
    do begin
      if (awready) stable = 1'b0;
      step();
      lat++;
    end while (!rvalid && lat < 50);
    chk("both_rvalid", 32'(rvalid), 32'd1);
    chk("both_aw_blocked", 32'(stable), 32'd1);
    chk("both_rdata", rdata, 32'h1122_AB44);
    r_take();
    chk("both_aw_after", 32'(awready), 32'd1);
    step();
    awvalid = 1'b0;
    chk("both_wready", 32'(wready), 32'd1);
    w_send(32'h0BAD_F00D, 4'b1111);
    b_wait("both_w", lat);
    chk("both_w_lat", 32'(lat), 32'(WRL));
    b_take();
    rd("r_both_w", 32'h8000_0020, 32'h0BAD_F00D, 2'b00);

    ar_req(32'h7FFF_FFF0);
    r_wait("rstall", lat);
    d0 = rdata;
    r0 = rresp;
    stable = 1'b1;
    awaddr = 32'h8000_0040;
    awvalid = 1'b1;
    repeat (5) begin
      step();
      if (!rvalid || rdata !== d0 || rresp !== r0) stable = 1'b0;
      if (arready || awready) stable = 1'b0;
    end
    awvalid = 1'b0;
    chk("rstall_stable", 32'(stable), 32'd1);
    chk("rstall_resp", 32'(rresp), 32'd2);
    r_take();

    aw_req(32'h7FFF_0000);
    w_send(32'h1234_5678, 4'b1111);
    b_wait("bstall", lat);
    r0 = bresp;
    stable = 1'b1;
    araddr = 32'h8000_0010;
    arvalid = 1'b1;
    repeat (3) begin
      step();
      if (!bvalid || bresp !== r0) stable = 1'b0;
      if (arready || awready) stable = 1'b0;
    end
    arvalid = 1'b0;
    chk("bstall_stable", 32'(stable), 32'd1);
    chk("bstall_resp", 32'(bresp), 32'd2);
    b_take();
    rd("r_after_stall", 32'h8000_0010, 32'h1122_AB44, 2'b00);

    aw_req(32'h8000_0030);
    w_send(32'h5A5A_5A5A, 4'b1111);
    step();
    rst_n = 1'b0;
    #1;
    chk("rstw_bvalid", 32'(bvalid), 32'd0);
    chk("rstw_arready", 32'(arready), 32'd1);
    chk("rstw_bresp", 32'(bresp), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    rd("r_partial", 32'h8000_0030, 32'h5A5A_5A5A, 2'b00);

    ar_req(32'h8000_0020);
    r_wait("rstr", lat);
    rst_n = 1'b0;
    #1;
    chk("rstr_rvalid", 32'(rvalid), 32'd0);
    chk("rstr_rdata", rdata, 32'd0);
    chk("rstr_arready", 32'(arready), 32'd1);
    #2;
    rst_n = 1'b1;
    step();
    rd("r_post_rst", 32'h8000_0020, 32'h0BAD_F00D, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
